// File: rtl/duty_table_pkg.sv
// Shared constants, types and the arcsine init law for the duty lookup table.
// The law is only evaluated when DUTY_TABLE_ASIN_INIT_EN is defined.
package duty_table_pkg;

  localparam int  DUTY_TABLE_DEPTH     = 65536;
  localparam int  DUTY_TABLE_ADDR_W    = 16;
  localparam int  DUTY_TABLE_DATA_W    = 8;
  localparam int  DUTY_ASIN_FULL_SCALE = 65025;
  localparam real DUTY_PI              = 3.14159265358979323846;

  typedef logic [DUTY_TABLE_ADDR_W-1:0] duty_idx_t;
  typedef logic [DUTY_TABLE_DATA_W-1:0] duty_value_t;

  // asin(i/65025)/pi*512 rounded to nearest; the full-scale point (256) and
  // every out-of-domain index land on 0 once truncated to 8 bits.
  function automatic duty_value_t duty_asin_entry(input int i);
    real r;
    int  v;
    if (i > DUTY_ASIN_FULL_SCALE) begin
      return '0;
    end
    r = $asin(real'(i) / real'(DUTY_ASIN_FULL_SCALE)) / DUTY_PI * 512.0;
    v = $rtoi(r + 0.5);
    return duty_value_t'(v);
  endfunction

endpackage

// File: rtl/duty_table_bram.sv
// Simple dual-port table RAM: word-wide (two-entry) write port, one-entry
// read-first registered read port. Preload selected by DUTY_TABLE_ASIN_INIT_EN.
module duty_table_bram
  import duty_table_pkg::*;
#(
  parameter int DEPTH  = DUTY_TABLE_DEPTH,
  parameter int DATA_W = DUTY_TABLE_DATA_W
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-2:0]   i_waddr,
  input  logic [2*DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_W-1:0]          o_rdata
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WORDS = DEPTH / 2;

  typedef logic [DATA_W-1:0] lane_t [WORDS];

`ifdef DUTY_TABLE_ASIN_INIT_EN
  function automatic lane_t lane_init(input int lane);
    lane_t t;
    for (int w = 0; w < WORDS; w++) begin
      t[w] = DATA_W'(duty_asin_entry(2 * w + lane));
    end
    return t;
  endfunction
`endif

  logic [2*DATA_W-1:0] w_lane_rd;
  logic                r_sel;

  // Lane 0 holds even entries (low byte), lane 1 odd entries (high byte).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
`ifdef DUTY_TABLE_ASIN_INIT_EN
      lane_t r_mem = lane_init(gi);
`else
      lane_t r_mem = '{default: '0};
`endif
      logic [DATA_W-1:0] r_rd;

      always_ff @(posedge clk) begin
        if (i_we) begin
          r_mem[i_waddr] <= i_wdata[gi*DATA_W +: DATA_W];
        end
        r_rd <= r_mem[i_raddr[AW-1:1]];
      end

      assign w_lane_rd[gi*DATA_W +: DATA_W] = r_rd;
    end
  endgenerate

  always_ff @(posedge clk) begin
    r_sel <= i_raddr[0];
  end

  assign o_rdata = r_sel ? w_lane_rd[2*DATA_W-1:DATA_W] : w_lane_rd[DATA_W-1:0];

endmodule

// File: rtl/duty_table_memory.sv
// Duty lookup table top: host write staging, index register, output register.
// Initial contents depend on DUTY_TABLE_ASIN_INIT_EN (see duty_table_bram).
module duty_table_memory
  import duty_table_pkg::*;
#(
  parameter int DEPTH  = DUTY_TABLE_DEPTH,
  parameter int ADDR_W = DUTY_TABLE_ADDR_W,
  parameter int DATA_W = DUTY_TABLE_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BUS_WE,
  input  logic [ADDR_W-2:0]     BUS_ADDR,
  input  logic [2*DATA_W-1:0]   BUS_DATA,
  input  logic [ADDR_W-1:0]     IDX,
  output logic [DATA_W-1:0]     VALUE
);

  logic                r_we;
  logic [ADDR_W-2:0]   r_waddr;
  logic [2*DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_vld;
  logic [DATA_W-1:0]   r_value;
  logic [DATA_W-1:0]   w_rd;

  // Writes commit one edge late so they land alongside the RAM read of the
  // index sampled with them: that read sees old data, the next index the new.
  // Left out of reset so a write just before reset is never dropped.
  always_ff @(posedge CLK) begin
    r_we    <= BUS_WE;
    r_waddr <= BUS_ADDR;
    r_wdata <= BUS_DATA;
  end

  // r_vld masks the unreset RAM read register until the pipe refills.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx   <= '0;
      r_vld   <= '0;
      r_value <= '0;
    end else begin
      r_idx   <= IDX;
      r_vld   <= {r_vld[0], 1'b1};
      r_value <= r_vld[1] ? w_rd : '0;
    end
  end

  duty_table_bram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_bram (
    .clk     (CLK),
    .i_we    (r_we),
    .i_waddr (r_waddr),
    .i_wdata (r_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_rd)
  );

  assign VALUE = r_value;

endmodule

// File: tb/tb_duty_table_memory.sv
// Directed bench for duty_table_memory; expectations follow the build's
// DUTY_TABLE_ASIN_INIT_EN setting.
module tb_duty_table_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_we;
  logic [14:0] bus_addr;
  logic [15:0] bus_data;
  logic [15:0] idx;
  logic [7:0]  value;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [65536];

  always #5 clk = ~clk;

  duty_table_memory dut (
    .CLK      (clk),
    .RST      (rst),
    .BUS_WE   (bus_we),
    .BUS_ADDR (bus_addr),
    .BUS_DATA (bus_data),
    .IDX      (idx),
    .VALUE    (value)
  );

`ifdef DUTY_TABLE_ASIN_INIT_EN
  function automatic logic [7:0] asin_ref(input int i);
    real r;
    if (i > 65025) return 8'h00;
    r = $asin(i / 65025.0) * 512.0 / 3.14159265358979;
    return 8'($rtoi(r + 0.5));
  endfunction
`endif

  task automatic test_reset();
    rst = 1'b1; bus_we = 1'b0; bus_addr = '0; bus_data = '0; idx = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (value !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d got=%02h exp=00", k, value);
      end
    end
    @(negedge clk); rst = 1'b0;
    $display("[TB] reset released");
  endtask

  // Spot entries with hand-derived values, then a wrapping sweep 61440..4095.
  task automatic test_init_contents();
    logic [15:0] sidx [6] = '{16'd0, 16'd32512, 16'd65025, 16'd65535, 16'd65024, 16'd1};
`ifdef DUTY_TABLE_ASIN_INIT_EN
    logic [7:0]  sexp [6] = '{8'd0, 8'd85, 8'd0, 8'd0, 8'd255, 8'd0};
`else
    logic [7:0]  sexp [6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
    int q[$];
    int e;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        tests++;
        if (value !== sexp[k-3]) begin
          fails++;
          $display("FAIL init_spot idx=%0d got=%0d exp=%0d", sidx[k-3], value, sexp[k-3]);
        end else begin
          $display("[TB] init_spot idx=%0d value=%0d", sidx[k-3], value);
        end
      end
      if (k < 6) idx = sidx[k];
    end
    for (int k = 0; k < 8192 + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        e = q.pop_front();
        tests++;
        if (value !== model[e]) begin
          fails++;
          $display("FAIL init_sweep idx=%0d got=%02h exp=%02h", e, value, model[e]);
        end
      end
      if (k < 8192) begin
        idx = 16'(61440 + k);
        q.push_back(int'(idx));
      end
    end
    $display("[TB] init sweep done");
  endtask

  task automatic test_upload();
    int a;
    int e;
    int q[$];
    logic [15:0] d;
    for (int w = 0; w < 2048; w++) begin
      a = (w < 1024) ? w : 31744 + (w - 1024);
      d = 16'($urandom);
      @(negedge clk);
      bus_we = 1'b1; bus_addr = 15'(a); bus_data = d;
      model[2*a]   = d[7:0];
      model[2*a+1] = d[15:8];
    end
    @(negedge clk); bus_we = 1'b0;
    // Continuous sweep 63488..65535 then 0..2047 exercises the wrap too.
    for (int k = 0; k < 4096 + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        e = q.pop_front();
        tests++;
        if (value !== model[e]) begin
          fails++;
          $display("FAIL upload_sweep idx=%0d got=%02h exp=%02h", e, value, model[e]);
        end
      end
      if (k < 4096) begin
        idx = 16'(63488 + k);
        q.push_back(int'(idx));
      end
    end
    $display("[TB] upload sweep done");
  endtask

  task automatic test_wrap();
    int e;
    int q[$];
    for (int k = 0; k < 12 + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        e = q.pop_front();
        tests++;
        if (value !== model[e]) begin
          fails++;
          $display("FAIL wrap idx=%0d got=%02h exp=%02h", e, value, model[e]);
        end else begin
          $display("[TB] wrap idx=%0d value=%02h", e, value);
        end
      end
      if (k < 12) begin
        idx = 16'(65530 + k);
        q.push_back(int'(idx));
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0]  cexp [3] = '{8'h34, 8'h5A, 8'hA5};
    logic [15:0] cidx [3] = '{16'h0020, 16'h0020, 16'h0021};
    @(negedge clk);
    bus_we = 1'b1; bus_addr = 15'h10; bus_data = 16'h1234; idx = 16'h0;
    @(negedge clk); bus_we = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 3) begin
        tests++;
        if (value !== cexp[k-3]) begin
          fails++;
          $display("FAIL collision step=%0d idx=%02h got=%02h exp=%02h", k-3, cidx[k-3], value, cexp[k-3]);
        end else begin
          $display("[TB] collision step=%0d idx=%02h value=%02h", k-3, cidx[k-3], value);
        end
      end
      if (k == 0) begin
        bus_we = 1'b1; bus_addr = 15'h10; bus_data = 16'hA55A;
      end else begin
        bus_we = 1'b0;
      end
      if (k < 3) idx = cidx[k];
    end
    model[32'h20] = 8'h5A;
    model[32'h21] = 8'hA5;
  endtask

  task automatic test_midstream_reset();
    int e;
    int q[$];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        e = q.pop_front();
        tests++;
        if (value !== model[e]) begin
          fails++;
          $display("FAIL pre_reset idx=%0d got=%02h exp=%02h", e, value, model[e]);
        end
      end
      idx = 16'(k * 7);
      q.push_back(int'(idx));
    end
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (value !== 8'h00) begin
      fails++;
      $display("FAIL reset_async got=%02h exp=00", value);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (value !== 8'h00) begin
        fails++;
        $display("FAIL reset_mid_hold cyc=%0d got=%02h exp=00", k, value);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idx = 16'd100;
    q.push_back(100);
    for (int k = 1; k < 40 + 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        tests++;
        if (value !== 8'h00) begin
          fails++;
          $display("FAIL refill cyc=%0d got=%02h exp=00", k, value);
        end
      end else begin
        e = q.pop_front();
        tests++;
        if (value !== model[e]) begin
          fails++;
          $display("FAIL post_reset idx=%0d got=%02h exp=%02h", e, value, model[e]);
        end
      end
      if (k < 40) begin
        idx = 16'(100 + k);
        q.push_back(int'(idx));
      end
    end
    $display("[TB] midstream reset done");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
`ifdef DUTY_TABLE_ASIN_INIT_EN
      model[i] = asin_ref(i);
`else
      model[i] = 8'h00;
`endif
    end
    test_reset();
    test_init_contents();
    test_upload();
    test_wrap();
    test_collision();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
